gesture_frame_sequencer: RTL and testbench
==========================================

Name: gesture_frame_sequencer

Overview:
Frame-level controller for the finger-counting datapath.
- Runs the pipeline as a repeating schedule of frames: bounding-box frame, edge-buffer clear sweep, edge-build frame, count frame, publish.
- Drives per-frame phase enables and a sequential edge-buffer clear port, and latches and validates the hand bounding box.
- Debounces the per-frame finger count before presenting it to the LED/display logic.
- Sits between the VGA timing generator and the bbox / edge-buffer / fingertip-count blocks.

Parameters:
H_LAST, 639, last active pixel_x
V_LAST, 479, last active pixel_y
V_ACTIVE, 480, edge-buffer depth (entries cleared per sweep)
MAX_FINGERS, 5, largest legal finger count
STABLE_N, 2, consecutive equal counts required to publish (1..7)

Ports:
vga_clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request from mode logic
pixel_x  in  10  current scan column
pixel_y  in  10  current scan row
bbox_left  in  10  hand left bound from bbox finder
bbox_right  in  10  hand right bound
bbox_top  in  10  hand top bound
bbox_bottom  in  10  hand bottom bound
finger_tmp  in  4  running fingertip count from count block
left_q/right_q/top_q/bottom_q  out  10 each  latched, validated bbox
phase_bbox  out  1  bbox frame active
phase_build  out  1  edge-buffer build frame active
phase_count  out  1  fingertip count frame active
count_clr  out  1  clears count block accumulator (high throughout BUILD)
buf_clr_we  out  1  edge-buffer clear write strobe
buf_clr_addr  out  9  edge-buffer clear row address
finger_number  out  4  debounced published count
result_valid  out  1  one-cycle pulse on new published count
frame_err  out  1  one-cycle pulse: invalid bbox or illegal count
state_dbg  out  3  current state encoding

Behaviour:
- Reset rst_n, asynchronous, active-low; clock vga_clk. All outputs, bbox registers, candidate and match counter reset to 0; state to IDLE.
- sof = (pixel_x==0 && pixel_y==0); eof = (pixel_x==H_LAST && pixel_y==V_LAST); both combinational from inputs, acted on at that clock edge.
- Phase outputs are registered decodes of state: phase_bbox=BBOX, phase_build=BUILD, phase_count=COUNT, count_clr=BUILD, buf_clr_we=CLEAR.
- States: IDLE=0, BBOX=1, CLEAR=2, WAIT_B=3, BUILD=4, COUNT=5, PUBLISH=6.
- IDLE: enable && sof -> BBOX.
- BBOX, on eof:
  - Latch bbox_* into *_q.
  - Valid if left<right, top<bottom and bottom<=V_LAST: go to CLEAR, buf_clr_addr=0.
  - Otherwise: frame_err pulse, *_q still updated, stay BBOX.
- CLEAR:
  - buf_clr_we=1 for exactly V_ACTIVE consecutive cycles, buf_clr_addr 0..V_ACTIVE-1, incrementing by 1 per cycle.
  - The cycle addr==V_ACTIVE-1 is written -> WAIT_B; addr returns to 0.
  - sof during CLEAR is ignored, so BUILD slips one frame.
- WAIT_B: sof -> BUILD.
- BUILD: eof -> COUNT.
- COUNT: eof -> PUBLISH; finger_tmp is sampled on the same edge.
- PUBLISH (one cycle), then go to BBOX if enable, else IDLE.
  - Sample > MAX_FINGERS: frame_err pulse; candidate and match counter unchanged.
  - Sample == candidate: match_cnt increments, saturating at STABLE_N.
  - Sample != candidate: candidate <= sample, match_cnt <= 1.
  - When match_cnt newly becomes STABLE_N (including STABLE_N==1 on a mismatch load): finger_number <= candidate, result_valid pulse. No pulse while match_cnt is already saturated.
- enable low in any non-IDLE state -> IDLE on next edge.
  - Phases and buf_clr_we drop that cycle; an in-progress sweep is abandoned (buf_clr_addr -> 0).
  - finger_number, candidate and match_cnt are held.
- sof and eof never coincide. eof arriving in BUILD/COUNT while enable is low is irrelevant (already IDLE).
- Outputs must not glitch: every output is driven from a flop.

Test Plan:
- Enable at sof; bbox=(100,300,50,400); finger_tmp=3 at two COUNT eofs; STABLE_N=2 -> first PUBLISH no pulse; second PUBLISH result_valid=1 for 1 cycle, finger_number=3.
- bbox left=300, right=100 at BBOX eof -> frame_err 1-cycle pulse, state_dbg stays 1, buf_clr_we never asserts.
- Valid bbox eof -> buf_clr_we high exactly 480 cycles starting next cycle, buf_clr_addr 0..479, then state_dbg=3; BUILD begins at the following sof.
- finger_tmp alternating 2,4,2,4 over four rounds -> no result_valid, finger_number holds prior value; then 6 sampled -> frame_err pulse, candidate unchanged.
- enable deasserted mid-BUILD -> next edge state_dbg=0, phase_build=0, count_clr=0; re-enable -> BBOX at next sof.
- Assert rst_n=0 mid-CLEAR (addr≈200) -> all outputs 0 immediately and asynchronously; after release state_dbg=0.

Source files
------------

// File: rtl/gesture_frame_sequencer.sv
// Frame scheduler for the finger-counting datapath: bbox latch,
// edge-buffer clear sweep, per-frame phase enables, count debounce.
module gesture_frame_sequencer #(
  parameter int H_LAST      = 639,
  parameter int V_LAST      = 479,
  parameter int V_ACTIVE    = 480,
  parameter int MAX_FINGERS = 5,
  parameter int STABLE_N    = 2
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [9:0] bbox_left,
  input  logic [9:0] bbox_right,
  input  logic [9:0] bbox_top,
  input  logic [9:0] bbox_bottom,
  input  logic [3:0] finger_tmp,
  output logic [9:0] left_q,
  output logic [9:0] right_q,
  output logic [9:0] top_q,
  output logic [9:0] bottom_q,
  output logic       phase_bbox,
  output logic       phase_build,
  output logic       phase_count,
  output logic       count_clr,
  output logic       buf_clr_we,
  output logic [8:0] buf_clr_addr,
  output logic [3:0] finger_number,
  output logic       result_valid,
  output logic       frame_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BBOX    = 3'd1,
    CLEAR   = 3'd2,
    WAIT_B  = 3'd3,
    BUILD   = 3'd4,
    COUNT   = 3'd5,
    PUBLISH = 3'd6
  } state_t;

  localparam logic [9:0] HL = 10'(H_LAST);
  localparam logic [9:0] VL = 10'(V_LAST);
  localparam logic [8:0] CL = 9'(V_ACTIVE - 1);
  localparam logic [3:0] MF = 4'(MAX_FINGERS);
  localparam logic [2:0] SN = 3'(STABLE_N);

  state_t     state_q, state_d;
  logic [9:0] left_d, right_d, top_d, bottom_d;
  logic [8:0] addr_q, addr_d;
  logic [3:0] sample_q, sample_d;
  logic [3:0] cand_q, cand_d;
  logic [2:0] match_q, match_d;
  logic [3:0] fnum_q, fnum_d;
  logic       rv_q, rv_d;
  logic       err_q, err_d;
  logic       pbb_q, pbb_d;
  logic       pbu_q, pbu_d;
  logic       pco_q, pco_d;
  logic       ccl_q, ccl_d;
  logic       we_q, we_d;
  logic       sof, eof, bbox_ok;

  assign sof = (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign eof = (pixel_x == HL) && (pixel_y == VL);

  assign bbox_ok = (bbox_left < bbox_right)
                && (bbox_top < bbox_bottom)
                && (bbox_bottom <= VL);

  always_comb begin
    state_d  = state_q;
    left_d   = left_q;
    right_d  = right_q;
    top_d    = top_q;
    bottom_d = bottom_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    cand_d   = cand_q;
    match_d  = match_q;
    fnum_d   = fnum_q;
    rv_d     = 1'b0;
    err_d    = 1'b0;

    if (state_q != IDLE && !enable) begin
      // Abandon the frame; debounce history is kept.
      state_d = IDLE;
      addr_d  = 9'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && sof)
            state_d = BBOX;
        end
        BBOX: begin
          if (eof) begin
            left_d   = bbox_left;
            right_d  = bbox_right;
            top_d    = bbox_top;
            bottom_d = bbox_bottom;
            if (bbox_ok) begin
              state_d = CLEAR;
              addr_d  = 9'd0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CLEAR: begin
          if (addr_q == CL) begin
            state_d = WAIT_B;
            addr_d  = 9'd0;
          end else begin
            addr_d = addr_q + 9'd1;
          end
        end
        WAIT_B: begin
          if (sof)
            state_d = BUILD;
        end
        BUILD: begin
          if (eof)
            state_d = COUNT;
        end
        COUNT: begin
          if (eof) begin
            sample_d = finger_tmp;
            state_d  = PUBLISH;
          end
        end
        PUBLISH: begin
          state_d = BBOX;
          if (sample_q > MF) begin
            err_d = 1'b1;
          end else if (sample_q == cand_q) begin
            // Saturated run publishes only once.
            if (match_q != SN) begin
              match_d = match_q + 3'd1;
              if (match_q + 3'd1 == SN) begin
                fnum_d = sample_q;
                rv_d   = 1'b1;
              end
            end
          end else begin
            cand_d  = sample_q;
            match_d = 3'd1;
            if (SN == 3'd1) begin
              fnum_d = sample_q;
              rv_d   = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    pbb_d = (state_d == BBOX);
    pbu_d = (state_d == BUILD);
    pco_d = (state_d == COUNT);
    ccl_d = (state_d == BUILD);
    we_d  = (state_d == CLEAR);
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      left_q   <= 10'd0;
      right_q  <= 10'd0;
      top_q    <= 10'd0;
      bottom_q <= 10'd0;
      addr_q   <= 9'd0;
      sample_q <= 4'd0;
      cand_q   <= 4'd0;
      match_q  <= 3'd0;
      fnum_q   <= 4'd0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      pbb_q    <= 1'b0;
      pbu_q    <= 1'b0;
      pco_q    <= 1'b0;
      ccl_q    <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      left_q   <= left_d;
      right_q  <= right_d;
      top_q    <= top_d;
      bottom_q <= bottom_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      fnum_q   <= fnum_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      pbb_q    <= pbb_d;
      pbu_q    <= pbu_d;
      pco_q    <= pco_d;
      ccl_q    <= ccl_d;
      we_q     <= we_d;
    end
  end

  assign phase_bbox    = pbb_q;
  assign phase_build   = pbu_q;
  assign phase_count   = pco_q;
  assign count_clr     = ccl_q;
  assign buf_clr_we    = we_q;
  assign buf_clr_addr  = addr_q;
  assign finger_number = fnum_q;
  assign result_valid  = rv_q;
  assign frame_err     = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_gesture_frame_sequencer.sv
// Bench for gesture_frame_sequencer: frame-level model plus
// directed scenarios with hand-computed expectations.
module tb_gesture_frame_sequencer;

  logic       vga_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       enable;
  logic [9:0] pixel_x, pixel_y;
  logic [9:0] bbox_left, bbox_right, bbox_top, bbox_bottom;
  logic [3:0] finger_tmp;
  logic [9:0] left_q, right_q, top_q, bottom_q;
  logic       phase_bbox, phase_build, phase_count, count_clr;
  logic       buf_clr_we;
  logic [8:0] buf_clr_addr;
  logic [3:0] finger_number;
  logic       result_valid, frame_err;
  logic [2:0] state_dbg;

  gesture_frame_sequencer dut (
    .vga_clk      (vga_clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .bbox_left    (bbox_left),
    .bbox_right   (bbox_right),
    .bbox_top     (bbox_top),
    .bbox_bottom  (bbox_bottom),
    .finger_tmp   (finger_tmp),
    .left_q       (left_q),
    .right_q      (right_q),
    .top_q        (top_q),
    .bottom_q     (bottom_q),
    .phase_bbox   (phase_bbox),
    .phase_build  (phase_build),
    .phase_count  (phase_count),
    .count_clr    (count_clr),
    .buf_clr_we   (buf_clr_we),
    .buf_clr_addr (buf_clr_addr),
    .finger_number(finger_number),
    .result_valid (result_valid),
    .frame_err    (frame_err),
    .state_dbg    (state_dbg)
  );

  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_we  = 0;
  int n_rv  = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Frame-level model: which frame we are in, how far the sweep
  // has got, and the run length of identical legal samples.
  int         m_st, m_idx, m_run, m_last, m_samp;
  logic [9:0] m_l, m_r, m_t, m_b;
  logic [3:0] m_fn;
  logic       m_rv, m_err;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_run = 0; m_last = 0; m_samp = 0;
    m_l = '0; m_r = '0; m_t = '0; m_b = '0;
    m_fn = '0; m_rv = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit s, e;
    s = (pixel_x == 0) && (pixel_y == 0);
    e = (pixel_x == 639) && (pixel_y == 479);
    m_rv  = 1'b0;
    m_err = 1'b0;
    if (m_st != 0 && !enable) begin
      m_st  = 0;
      m_idx = 0;
    end else begin
      case (m_st)
        0: if (enable && s) m_st = 1;
        1: if (e) begin
             m_l = bbox_left;  m_r = bbox_right;
             m_t = bbox_top;   m_b = bbox_bottom;
             if (bbox_left < bbox_right && bbox_top < bbox_bottom
                 && bbox_bottom <= 479) begin
               m_st  = 2;
               m_idx = 0;
             end else begin
               m_err = 1'b1;
             end
           end
        2: if (m_idx == 479) begin
             m_st  = 3;
             m_idx = 0;
           end else begin
             m_idx++;
           end
        3: if (s) m_st = 4;
        4: if (e) m_st = 5;
        5: if (e) begin
             m_samp = finger_tmp;
             m_st   = 6;
           end
        6: begin
             if (m_samp > 5) begin
               m_err = 1'b1;
             end else begin
               if (m_samp == m_last) m_run++;
               else begin
                 m_last = m_samp;
                 m_run  = 1;
               end
               if (m_run == 2) begin
                 m_fn = m_samp[3:0];
                 m_rv = 1'b1;
               end
             end
             m_st = 1;
           end
        default: ;
      endcase
    end
  endtask

  always @(negedge vga_clk) begin
    if (chk_on) begin
      chk("state_dbg",     state_dbg,     m_st);
      chk("phase_bbox",    phase_bbox,    m_st == 1);
      chk("phase_build",   phase_build,   m_st == 4);
      chk("phase_count",   phase_count,   m_st == 5);
      chk("count_clr",     count_clr,     m_st == 4);
      chk("buf_clr_we",    buf_clr_we,    m_st == 2);
      chk("buf_clr_addr",  buf_clr_addr,  m_idx);
      chk("finger_number", finger_number, m_fn);
      chk("result_valid",  result_valid,  m_rv);
      chk("frame_err",     frame_err,     m_err);
      chk("left_q",        left_q,        m_l);
      chk("right_q",       right_q,       m_r);
      chk("top_q",         top_q,         m_t);
      chk("bottom_q",      bottom_q,      m_b);
      if (buf_clr_we)   n_we++;
      if (result_valid) n_rv++;
      if (frame_err)    n_err++;
    end
  end

  // One pixel clock: inputs apply over the next rising edge, and
  // control returns just after the following falling edge.
  task automatic drive(input logic [9:0] x, input logic [9:0] y);
    pixel_x = x;
    pixel_y = y;
    @(posedge vga_clk);
    if (rst_n) model_step();
    @(negedge vga_clk);
    #1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) drive(10'd5, 10'd5);
  endtask

  task automatic sof_c();
    drive(10'd0, 10'd0);
  endtask

  task automatic eof_c();
    drive(10'd639, 10'd479);
  endtask

  task automatic set_bbox(input int l, input int r,
                          input int t, input int b);
    bbox_left   = 10'(l);
    bbox_right  = 10'(r);
    bbox_top    = 10'(t);
    bbox_bottom = 10'(b);
  endtask

  // Full schedule starting in BBOX with a valid box loaded.
  task automatic round(input logic [3:0] ft);
    int w0;
    fill(2);
    w0 = n_we;
    eof_c();
    fill(100);
    sof_c();
    chk("clear_ignores_sof", state_dbg, 3'd2);
    fill(390);
    chk("clr_len", n_we - w0, 480);
    chk("wait_b", state_dbg, 3'd3);
    sof_c();
    chk("build", state_dbg, 3'd4);
    fill(3);
    eof_c();
    chk("count", state_dbg, 3'd5);
    fill(3);
    finger_tmp = ft;
    eof_c();
    chk("publish", state_dbg, 3'd6);
    fill(2);
    chk("back_bbox", state_dbg, 3'd1);
  endtask

  initial begin
    int r0, e0, w0;
    enable = 1'b1;
    pixel_x = 10'd5;
    pixel_y = 10'd5;
    set_bbox(100, 300, 50, 400);
    finger_tmp = 4'd0;
    model_reset();
    repeat (3) @(negedge vga_clk);
    #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;
    chk("reset_state", state_dbg, 3'd0);
    chk("reset_fnum", finger_number, 4'd0);

    fill(3);
    chk("idle_wait_sof", state_dbg, 3'd0);
    sof_c();
    chk("to_bbox", state_dbg, 3'd1);

    r0 = n_rv;
    round(4'd3);
    chk("first_publish_no_pulse", n_rv - r0, 0);
    round(4'd3);
    chk("second_publish_pulse", n_rv - r0, 1);
    chk("fnum_3", finger_number, 4'd3);
    chk("left_latched", left_q, 10'd100);
    chk("bottom_latched", bottom_q, 10'd400);

    e0 = n_err;
    w0 = n_we;
    fill(2);
    set_bbox(300, 100, 50, 400);
    eof_c();
    chk("bad_lr_err", frame_err, 1'b1);
    chk("bad_lr_state", state_dbg, 3'd1);
    chk("bad_lr_latched", left_q, 10'd300);
    fill(2);
    chk("err_one_cycle", frame_err, 1'b0);
    set_bbox(100, 300, 60, 60);
    eof_c();
    fill(2);
    set_bbox(100, 300, 50, 480);
    eof_c();
    fill(2);
    chk("bad_bbox_errs", n_err - e0, 3);
    chk("bad_bbox_no_clear", n_we - w0, 0);
    chk("bad_bbox_stay", state_dbg, 3'd1);

    set_bbox(100, 300, 50, 479);
    r0 = n_rv;
    round(4'd2);
    round(4'd4);
    round(4'd2);
    round(4'd4);
    chk("alt_no_pulse", n_rv - r0, 0);
    chk("alt_fnum_held", finger_number, 4'd3);
    chk("bottom_479_ok", bottom_q, 10'd479);
    e0 = n_err;
    round(4'd6);
    chk("illegal_err", n_err - e0, 1);
    chk("illegal_no_pulse", n_rv - r0, 0);
    round(4'd4);
    chk("cand_kept_pulse", n_rv - r0, 1);
    chk("fnum_4", finger_number, 4'd4);

    fill(2);
    eof_c();
    fill(491);
    sof_c();
    fill(3);
    chk("in_build", phase_build, 1'b1);
    enable = 1'b0;
    fill(1);
    chk("dis_state", state_dbg, 3'd0);
    chk("dis_build", phase_build, 1'b0);
    chk("dis_cclr", count_clr, 1'b0);
    chk("dis_fnum_held", finger_number, 4'd4);
    enable = 1'b1;
    fill(3);
    chk("reen_wait", state_dbg, 3'd0);
    sof_c();
    chk("reen_bbox", state_dbg, 3'd1);

    fill(2);
    eof_c();
    fill(200);
    chk("mid_clear_we", buf_clr_we, 1'b1);
    chk("mid_clear_addr", buf_clr_addr, 9'd200);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_we", buf_clr_we, 1'b0);
    chk("rst_addr", buf_clr_addr, 9'd0);
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_fnum", finger_number, 4'd0);
    chk("rst_left", left_q, 10'd0);
    fill(2);
    rst_n = 1'b1;
    fill(2);
    chk("post_rst_state", state_dbg, 3'd0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
